// File: rtl/lane_distribution_pkg.sv
// lane_distribution_pkg: shared constants, FSM states and parameter checks for the lane distributor
package lane_distribution_pkg;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hB8;
  localparam logic [7:0] TRAIL_AFTER_ONE = 8'h00;
  localparam logic [7:0] TRAIL_AFTER_ZERO = 8'hFF;
  typedef enum logic [1:0] {IDLE, SYNC, DATA, TRAIL} state_e;
  function automatic bit lanes_ok(input int n);
    return n == 2 || n == 4;
  endfunction
endpackage

// File: rtl/lane_distribution_trail_gen.sv
// lane_trail_gen: per-lane HS trail generator; remembers the last bit on the wire and counts trail bytes
module lane_trail_gen
  import lane_distribution_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clr_i,
  input  logic       cap_i,
  input  logic       bit_i,
  input  logic       start_i,
  input  logic       trail_i,
  input  logic [3:0] trail_len_i,
  output logic [7:0] trail_byte_o,
  output logic       active_o,
  output logic       done_o
);
  logic [3:0] cnt_q, cnt_d;
  logic       last_q, last_d;
  assign active_o = start_i || (trail_i && cnt_q < trail_len_i);
  assign done_o = trail_i && !active_o;
  assign trail_byte_o = last_q ? TRAIL_AFTER_ONE : TRAIL_AFTER_ZERO;
  assign cnt_d = clr_i ? 4'd0 : active_o ? cnt_q + 4'd1 : cnt_q;
  assign last_d = cap_i ? bit_i : last_q;
  always_ff @(posedge clk_i) begin
    cnt_q <= reset_i ? 4'd0 : cnt_d;
    last_q <= reset_i ? 1'b0 : last_d;
  end
endmodule

// File: rtl/lane_distribution.sv
// lane_distribution: CSI-2 TX byte-to-lane distributor emitting sync, round-robin data and per-lane HS trails
module lane_distribution
  import lane_distribution_pkg::*;
#(
  parameter int          LANES     = 4,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int          TRAIL_LEN = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [8*LANES-1:0] data_i,
  input  logic               data_valid_i,
  input  logic               data_last_i,
  input  logic [2:0]         data_bytes_i,
  output logic               data_ready_o,
  output logic [8*LANES-1:0] lane_byte_o,
  output logic [LANES-1:0]   lane_valid_o,
  output logic               busy_o,
  output logic               underrun_o
);
  if (!lanes_ok(LANES)) begin : g_bad_lanes
    $error("lane_distribution: LANES must be 2 or 4");
  end
  if (TRAIL_LEN < 1 || TRAIL_LEN > 15) begin : g_bad_trail
    $error("lane_distribution: TRAIL_LEN must be 1..15");
  end
  state_e             state_q, state_d;
  logic [8*LANES-1:0] byte_q, byte_d;
  logic [LANES-1:0]   valid_q, valid_d, send, start, act, done;
  logic               busy_q, under_q, under_d;
  logic               go, acc, under;
  logic [3:0]         nb;
  logic [7:0]         trail_b [LANES];
  assign data_ready_o = state_q == SYNC || state_q == DATA;
  assign go = state_q == IDLE && data_valid_i;
  assign acc = data_ready_o && data_valid_i;
  assign under = data_ready_o && !data_valid_i;
  // lanes at or beyond nb get no data this beat and begin their trail instead
  assign nb = (!data_last_i || data_bytes_i == 3'd0) ? 4'(LANES) : {1'b0, data_bytes_i};
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign send[i] = acc && 4'(i) < nb;
    assign start[i] = under || (acc && !send[i]);
    lane_trail_gen u_trail (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .clr_i        (state_q == IDLE),
      .cap_i        (go || send[i]),
      .bit_i        (go ? SYNC_BYTE[7] : data_i[8*i+7]),
      .start_i      (start[i]),
      .trail_i      (state_q == TRAIL),
      .trail_len_i  (4'(TRAIL_LEN)),
      .trail_byte_o (trail_b[i]),
      .active_o     (act[i]),
      .done_o       (done[i])
    );
    assign byte_d[8*i +: 8] = go ? SYNC_BYTE : send[i] ? data_i[8*i +: 8] : act[i] ? trail_b[i] : 8'h00;
    assign valid_d[i] = go || send[i] || act[i];
  end
  always_comb begin
    state_d = go ? SYNC : acc ? (data_last_i ? TRAIL : DATA) : under ? TRAIL :
              (state_q == TRAIL && &done) ? IDLE : state_q;
    under_d = go ? 1'b0 : under ? 1'b1 : under_q;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      byte_q  <= '0;
      valid_q <= '0;
      busy_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      busy_q  <= |valid_d;
      under_q <= under_d;
    end
  end
  assign lane_byte_o = byte_q;
  assign lane_valid_o = valid_q;
  assign busy_o = busy_q;
  assign underrun_o = under_q;
endmodule

// File: tb/tb_lane_distribution.sv
// tb_lane_distribution: directed checks of the lane distributor in 4-lane and 2-lane builds
module tb_lane_distribution;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] d;
  logic        v, l;
  logic [2:0]  nb;
  logic        rdy, bsy, und;
  logic [31:0] lb;
  logic [3:0]  lv;
  logic [15:0] d2, lb2;
  logic        v2, l2, rdy2, bsy2, und2;
  logic [2:0]  nb2;
  logic [1:0]  lv2;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  lane_distribution #(.LANES(4), .SYNC_BYTE(8'hB8), .TRAIL_LEN(2)) u4 (
    .clk_i(clk), .reset_i(rst), .data_i(d), .data_valid_i(v), .data_last_i(l),
    .data_bytes_i(nb), .data_ready_o(rdy), .lane_byte_o(lb), .lane_valid_o(lv),
    .busy_o(bsy), .underrun_o(und)
  );
  lane_distribution #(.LANES(2), .SYNC_BYTE(8'hB8), .TRAIL_LEN(2)) u2 (
    .clk_i(clk), .reset_i(rst), .data_i(d2), .data_valid_i(v2), .data_last_i(l2),
    .data_bytes_i(nb2), .data_ready_o(rdy2), .lane_byte_o(lb2), .lane_valid_o(lv2),
    .busy_o(bsy2), .underrun_o(und2)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic tick(input string tag, input logic [31:0] eb, input logic [3:0] ev, input logic eby, input logic eu);
    @(posedge clk);
    #1;
    chk({tag, ".byte"}, lb, eb);
    chk({tag, ".valid"}, 32'(lv), 32'(ev));
    chk({tag, ".busy"}, 32'(bsy), 32'(eby));
    chk({tag, ".under"}, 32'(und), 32'(eu));
  endtask
  task automatic tick2(input string tag, input logic [15:0] eb, input logic [1:0] ev, input logic eby);
    @(posedge clk);
    #1;
    chk({tag, ".byte"}, 32'(lb2), 32'(eb));
    chk({tag, ".valid"}, 32'(lv2), 32'(ev));
    chk({tag, ".busy"}, 32'(bsy2), 32'(eby));
    chk({tag, ".under"}, 32'(und2), 32'd0);
  endtask
  initial begin
    rst = 1'b1; v = 1'b0; l = 1'b0; nb = 3'd0; d = '0;
    v2 = 1'b0; l2 = 1'b0; nb2 = 3'd0; d2 = '0;
    tick("reset", 32'h0, 4'h0, 1'b0, 1'b0);
    chk("reset.rdy", 32'(rdy), 32'd0);
    rst = 1'b0;
    // two full beats, all lanes trail together
    v = 1'b1; d = 32'h04030201;
    tick("t1.sync", 32'hB8B8B8B8, 4'hF, 1'b1, 1'b0);
    chk("t1.rdy_sync", 32'(rdy), 32'd1);
    tick("t1.b1", 32'h04030201, 4'hF, 1'b1, 1'b0);
    d = 32'h08070605; l = 1'b1; nb = 3'd4;
    tick("t1.b2", 32'h08070605, 4'hF, 1'b1, 1'b0);
    v = 1'b0; l = 1'b0;
    chk("t1.rdy_trail", 32'(rdy), 32'd0);
    tick("t1.tr1", 32'hFFFFFFFF, 4'hF, 1'b1, 1'b0);
    tick("t1.tr2", 32'hFFFFFFFF, 4'hF, 1'b1, 1'b0);
    tick("t1.end", 32'h0, 4'h0, 1'b0, 1'b0);
    // short last beat: lanes 2/3 trail early
    v = 1'b1; d = 32'h84030281;
    tick("t2.sync", 32'hB8B8B8B8, 4'hF, 1'b1, 1'b0);
    tick("t2.b1", 32'h84030281, 4'hF, 1'b1, 1'b0);
    d = 32'hEEEE0685; l = 1'b1; nb = 3'd2;
    tick("t2.b2", 32'h00FF0685, 4'hF, 1'b1, 1'b0);
    v = 1'b0; l = 1'b0;
    tick("t2.tr1", 32'h00FFFF00, 4'hF, 1'b1, 1'b0);
    tick("t2.tr2", 32'h0000FF00, 4'h3, 1'b1, 1'b0);
    tick("t2.end", 32'h0, 4'h0, 1'b0, 1'b0);
    // single beat, one byte
    v = 1'b1; d = 32'h00000080; l = 1'b1; nb = 3'd1;
    tick("t3.sync", 32'hB8B8B8B8, 4'hF, 1'b1, 1'b0);
    tick("t3.b1", 32'h00000080, 4'hF, 1'b1, 1'b0);
    v = 1'b0; l = 1'b0;
    tick("t3.tr1", 32'h0, 4'hF, 1'b1, 1'b0);
    tick("t3.tr2", 32'h0, 4'h1, 1'b1, 1'b0);
    tick("t3.end", 32'h0, 4'h0, 1'b0, 1'b0);
    // underrun after the first beat, then recovery with bytes=0 meaning all lanes
    v = 1'b1; d = 32'h11223344;
    tick("t4.sync", 32'hB8B8B8B8, 4'hF, 1'b1, 1'b0);
    tick("t4.b1", 32'h11223344, 4'hF, 1'b1, 1'b0);
    v = 1'b0;
    tick("t4.ur", 32'hFFFFFFFF, 4'hF, 1'b1, 1'b1);
    tick("t4.tr2", 32'hFFFFFFFF, 4'hF, 1'b1, 1'b1);
    tick("t4.end", 32'h0, 4'h0, 1'b0, 1'b1);
    chk("t4.rdy_idle", 32'(rdy), 32'd0);
    v = 1'b1; d = 32'h80808080; l = 1'b1; nb = 3'd0;
    tick("t4.sync2", 32'hB8B8B8B8, 4'hF, 1'b1, 1'b0);
    tick("t4.b", 32'h80808080, 4'hF, 1'b1, 1'b0);
    v = 1'b0; l = 1'b0;
    tick("t4.tr1b", 32'h0, 4'hF, 1'b1, 1'b0);
    tick("t4.tr2b", 32'h0, 4'hF, 1'b1, 1'b0);
    tick("t4.endb", 32'h0, 4'h0, 1'b0, 1'b0);
    // reset in DATA aborts, next packet starts cleanly
    v = 1'b1; d = 32'h01010101;
    tick("t5.sync", 32'hB8B8B8B8, 4'hF, 1'b1, 1'b0);
    tick("t5.b1", 32'h01010101, 4'hF, 1'b1, 1'b0);
    rst = 1'b1;
    tick("t5.rst", 32'h0, 4'h0, 1'b0, 1'b0);
    chk("t5.rdy_rst", 32'(rdy), 32'd0);
    rst = 1'b0;
    tick("t5.sync2", 32'hB8B8B8B8, 4'hF, 1'b1, 1'b0);
    d = 32'h7F7F7F7F; l = 1'b1; nb = 3'd3;
    tick("t5.b", 32'h007F7F7F, 4'hF, 1'b1, 1'b0);
    v = 1'b0; l = 1'b0;
    tick("t5.tr1", 32'h00FFFFFF, 4'hF, 1'b1, 1'b0);
    tick("t5.tr2", 32'h00FFFFFF, 4'h7, 1'b1, 1'b0);
    tick("t5.end", 32'h0, 4'h0, 1'b0, 1'b0);
    // two-lane build: AA BB CC
    v2 = 1'b1; d2 = 16'hBBAA;
    tick2("t6.sync", 16'hB8B8, 2'h3, 1'b1);
    tick2("t6.b1", 16'hBBAA, 2'h3, 1'b1);
    d2 = 16'h00CC; l2 = 1'b1; nb2 = 3'd1;
    tick2("t6.b2", 16'h00CC, 2'h3, 1'b1);
    v2 = 1'b0; l2 = 1'b0;
    tick2("t6.tr1", 16'h0000, 2'h3, 1'b1);
    tick2("t6.tr2", 16'h0000, 2'h1, 1'b1);
    tick2("t6.end", 16'h0000, 2'h0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
